// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL bit positions and address-width helper for timer_multi
package timer_pkg;
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STAT   = 2'd1;
  localparam logic [1:0] OFF_RELOAD = 2'd2;
  localparam logic [1:0] OFF_COUNT  = 2'd3;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_OS       = 2;
  localparam int CTRL_PDIV_LSB = 8;
  // a single channel still keeps one index bit so the field is never empty
  function automatic int addr_w(input int n_ch);
    return (n_ch > 1 ? $clog2(n_ch) : 1) + 2;
  endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one prescaled up-counter with reload, one-shot mode, sticky flag and irq
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ctrl_we_i,
  input  logic        stat_we_i,
  input  logic        reload_we_i,
  input  logic        count_we_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] ctrl_o,
  output logic [15:0] reload_o,
  output logic [15:0] count_o,
  output logic        flag_o,
  output logic        irq_o
);
  logic             en_q, en_d, ie_q, ie_d, os_q, os_d, flag_q, flag_d, irq_q;
  logic [PRE_W-1:0] pdiv_q, pdiv_d, pcnt_q, pcnt_d;
  logic [CNT_W-1:0] reload_q, reload_d, count_q, count_d;
  logic             tick, ovf;
  logic             unused_wdata;
  assign unused_wdata = &{1'b0, wdata_i};
  always_comb begin
    tick     = en_q && (pcnt_q == pdiv_q);
    ovf      = tick && (count_q == '1);
    pcnt_d   = (ctrl_we_i || count_we_i || !en_q || tick) ? '0 : pcnt_q + 1'b1;
    en_d     = ctrl_we_i ? wdata_i[CTRL_EN] : (ovf && os_q) ? 1'b0 : en_q;
    ie_d     = ctrl_we_i ? wdata_i[CTRL_IE] : ie_q;
    os_d     = ctrl_we_i ? wdata_i[CTRL_OS] : os_q;
    pdiv_d   = ctrl_we_i ? wdata_i[CTRL_PDIV_LSB +: PRE_W] : pdiv_q;
    reload_d = reload_we_i ? wdata_i[CNT_W-1:0] : reload_q;
    count_d  = count_we_i ? wdata_i[CNT_W-1:0] : ovf ? reload_q : tick ? count_q + 1'b1 : count_q;
    // an overflow in the same cycle as a W1C keeps the flag set
    flag_d   = ovf || (flag_q && !(stat_we_i && wdata_i[0]));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      os_q     <= 1'b0;
      pdiv_q   <= '0;
      pcnt_q   <= '0;
      reload_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      ie_q     <= ie_d;
      os_q     <= os_d;
      pdiv_q   <= pdiv_d;
      pcnt_q   <= pcnt_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= flag_q && ie_q;
    end
  end
  assign ctrl_o   = {8'(pdiv_q), 5'b0, os_q, ie_q, en_q};
  assign reload_o = 16'(reload_q);
  assign count_o  = 16'(count_q);
  assign flag_o   = flag_q;
  assign irq_o    = irq_q;
endmodule

// File: rtl/timer_multi.sv
// timer_multi: N_CH-channel bus timer; address decode, read mux and interrupt OR
module timer_multi
  import timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8,
  localparam int AW   = addr_w(N_CH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sel,
  input  logic            i_we,
  input  logic            i_re,
  input  logic [AW-1:0]   i_addr,
  input  logic [15:0]     i_wdata,
  output logic [15:0]     o_rdata,
  output logic            o_rdy,
  output logic [N_CH-1:0] o_int_vec,
  output logic            o_int_req
);
  logic [AW-3:0] ch_idx;
  logic [1:0]    off;
  logic          hit, wr;
  logic [15:0]   rd [N_CH][4];
  logic [15:0]   rdata;
  assign ch_idx = i_addr[AW-1:2];
  assign off    = i_addr[1:0];
  assign hit    = i_sel && (32'(ch_idx) < N_CH);
  assign wr     = hit && i_we;
  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : g_ch
      logic we_c, flag;
      assign we_c = wr && (32'(ch_idx) == c);
      timer_channel #(.CNT_W(CNT_W), .PRE_W(PRE_W)) u_ch (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .ctrl_we_i   (we_c && off == OFF_CTRL),
        .stat_we_i   (we_c && off == OFF_STAT),
        .reload_we_i (we_c && off == OFF_RELOAD),
        .count_we_i  (we_c && off == OFF_COUNT),
        .wdata_i     (i_wdata),
        .ctrl_o      (rd[c][OFF_CTRL]),
        .reload_o    (rd[c][OFF_RELOAD]),
        .count_o     (rd[c][OFF_COUNT]),
        .flag_o      (flag),
        .irq_o       (o_int_vec[c])
      );
      assign rd[c][OFF_STAT] = {15'b0, flag};
    end
  endgenerate
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) rdata = (32'(ch_idx) == i) ? rd[i][off] : rdata;
  end
  assign o_rdata   = (hit && i_re) ? rdata : 16'h0;
  assign o_rdy     = i_sel;
  assign o_int_req = |o_int_vec;
endmodule
